// File: rtl/lsu_arbiter_if.sv
// Bundle of both requester ports and the shared LSU port of lsu_arbiter.
// The slave modport is the arbiter side. The master modport is the requester/LSU-model side.
interface lsu_arbiter_if;
  logic        i_m0_req;
  logic        i_m0_lock;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic        i_m0_wren;
  logic [2:0]  i_m0_funct3;
  logic        o_m0_gnt;
  logic        o_m0_rvalid;
  logic [31:0] o_m0_rdata;

  logic        i_m1_req;
  logic        i_m1_lock;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic        i_m1_wren;
  logic [2:0]  i_m1_funct3;
  logic        o_m1_gnt;
  logic        o_m1_rvalid;
  logic [31:0] o_m1_rdata;

  logic [31:0] o_lsu_addr;
  logic [31:0] o_lsu_st_data;
  logic        o_lsu_wren;
  logic [2:0]  o_lsu_funct3;
  logic [31:0] i_lsu_ld_data;
  logic [1:0]  o_owner;

  modport slave (
    input  i_m0_req, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_funct3,
    input  i_m1_req, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_funct3,
    input  i_lsu_ld_data,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    output o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_funct3, o_owner
  );

  modport master (
    output i_m0_req, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_funct3,
    output i_m1_req, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_funct3,
    output i_lsu_ld_data,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    input  o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_funct3, o_owner
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-master arbiter for the single LSU port: round-robin with a burst cap and an owner lock.
// Defining LSU_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins, except against a locked m1 owner).
module lsu_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input logic         i_clk,
  input logic         i_reset,
  lsu_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               gnt0, gnt1;
  logic               rd0, rd1;
  logic               rvalid0_q, rvalid1_q;
  logic [31:0]        rdata0_q, rdata1_q;

  // State, burst counter and round-robin pointer
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Grant decision and next-state
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    cnt_d   = '0;
    rr_d    = rr_q;

    if (bus.i_m0_req && !bus.i_m1_req) begin
      gnt0 = 1'b1;
    end else if (bus.i_m1_req && !bus.i_m0_req) begin
      gnt1 = 1'b1;
    end else if (bus.i_m0_req && bus.i_m1_req) begin
`ifdef LSU_ARB_FIXED_PRIO_EN
      if (state_q == OWN1 && bus.i_m1_lock) gnt1 = 1'b1;
      else                                  gnt0 = 1'b1;
`else
      case (state_q)
        OWN0: begin
          if (bus.i_m0_lock || cnt_q < CNT_W'(MAX_BURST)) gnt0 = 1'b1;
          else                                            gnt1 = 1'b1;
        end
        OWN1: begin
          if (bus.i_m1_lock || cnt_q < CNT_W'(MAX_BURST)) gnt1 = 1'b1;
          else                                            gnt0 = 1'b1;
        end
        default: begin
          if (rr_q) gnt1 = 1'b1;
          else      gnt0 = 1'b1;
        end
      endcase
`endif
    end

`ifdef LSU_ARB_FIXED_PRIO_EN
    rr_d = 1'b0;
    if (gnt0)      state_d = OWN0;
    else if (gnt1) state_d = OWN1;
`else
    // Counter saturates so a long locked run still yields once the lock drops
    if (gnt0) begin
      state_d = OWN0;
      rr_d    = 1'b1;
      if (state_q == OWN0) cnt_d = (cnt_q < CNT_W'(MAX_BURST)) ? cnt_q + CNT_W'(1) : cnt_q;
      else                 cnt_d = CNT_W'(1);
    end else if (gnt1) begin
      state_d = OWN1;
      rr_d    = 1'b0;
      if (state_q == OWN1) cnt_d = (cnt_q < CNT_W'(MAX_BURST)) ? cnt_q + CNT_W'(1) : cnt_q;
      else                 cnt_d = CNT_W'(1);
    end
`endif
  end

  assign rd0 = gnt0 && !bus.i_m0_wren;
  assign rd1 = gnt1 && !bus.i_m1_wren;

  // Load return: one-cycle valid, data held until the next load completes
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0) rdata0_q <= bus.i_lsu_ld_data;
      if (rd1) rdata1_q <= bus.i_lsu_ld_data;
    end
  end

  // LSU request mux; zeros when nothing is granted
  always_comb begin
    bus.o_lsu_addr    = '0;
    bus.o_lsu_st_data = '0;
    bus.o_lsu_wren    = 1'b0;
    bus.o_lsu_funct3  = '0;
    if (gnt0) begin
      bus.o_lsu_addr    = bus.i_m0_addr;
      bus.o_lsu_st_data = bus.i_m0_wdata;
      bus.o_lsu_wren    = bus.i_m0_wren;
      bus.o_lsu_funct3  = bus.i_m0_funct3;
    end else if (gnt1) begin
      bus.o_lsu_addr    = bus.i_m1_addr;
      bus.o_lsu_st_data = bus.i_m1_wdata;
      bus.o_lsu_wren    = bus.i_m1_wren;
      bus.o_lsu_funct3  = bus.i_m1_funct3;
    end
  end

  assign bus.o_m0_gnt    = gnt0;
  assign bus.o_m1_gnt    = gnt1;
  assign bus.o_m0_rvalid = rvalid0_q;
  assign bus.o_m1_rvalid = rvalid1_q;
  assign bus.o_m0_rdata  = rdata0_q;
  assign bus.o_m1_rdata  = rdata1_q;
  assign bus.o_owner     = state_q;
endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: reset, single reads and writes, round-robin burst cap, lock, and reset during a read.
module tb_lsu_arbiter;
  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  lsu_arbiter_if bus ();

  lsu_arbiter #(.MAX_BURST(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_m0_req = 1'b0; bus.i_m0_lock = 1'b0; bus.i_m0_addr = '0;
    bus.i_m0_wdata = '0; bus.i_m0_wren = 1'b0; bus.i_m0_funct3 = '0;
    bus.i_m1_req = 1'b0; bus.i_m1_lock = 1'b0; bus.i_m1_addr = '0;
    bus.i_m1_wdata = '0; bus.i_m1_wren = 1'b0; bus.i_m1_funct3 = '0;
    bus.i_lsu_ld_data = '0;
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later
  task automatic next_cycle();
    @(negedge i_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt0"},   32'(bus.o_m0_gnt), 32'd0);
    check({tag, "_gnt1"},   32'(bus.o_m1_gnt), 32'd0);
    check({tag, "_rv0"},    32'(bus.o_m0_rvalid), 32'd0);
    check({tag, "_rv1"},    32'(bus.o_m1_rvalid), 32'd0);
    check({tag, "_addr"},   bus.o_lsu_addr, 32'd0);
    check({tag, "_sdata"},  bus.o_lsu_st_data, 32'd0);
    check({tag, "_wren"},   32'(bus.o_lsu_wren), 32'd0);
    check({tag, "_f3"},     32'(bus.o_lsu_funct3), 32'd0);
    check({tag, "_owner"},  32'(bus.o_owner), 32'd0);
  endtask

  initial begin
    idle_inputs();
    #1 i_reset = 1'b0;

    // 1: reset state and release
    #10;
    check_idle("rst");
    check("rst_rd0", bus.o_m0_rdata, 32'd0);
    check("rst_rd1", bus.o_m1_rdata, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    next_cycle();
    check_idle("rel");

    // 2: m0 read, data one cycle later
    @(negedge i_clk);
    bus.i_m0_req = 1'b1; bus.i_m0_addr = 32'h10; bus.i_m0_funct3 = 3'b010;
    bus.i_lsu_ld_data = 32'hDEADBEEF;
    #1;
    check("rd0_gnt0", 32'(bus.o_m0_gnt), 32'd1);
    check("rd0_gnt1", 32'(bus.o_m1_gnt), 32'd0);
    check("rd0_addr", bus.o_lsu_addr, 32'h10);
    check("rd0_f3",   32'(bus.o_lsu_funct3), 32'd2);
    check("rd0_wren", 32'(bus.o_lsu_wren), 32'd0);
    @(negedge i_clk);
    idle_inputs();
    #1;
    check("rd0_rv0",   32'(bus.o_m0_rvalid), 32'd1);
    check("rd0_data",  bus.o_m0_rdata, 32'hDEADBEEF);
    check("rd0_rv1",   32'(bus.o_m1_rvalid), 32'd0);
    check("rd0_owner", 32'(bus.o_owner), 32'd1);
    next_cycle();
    check("rd0_rv0_off", 32'(bus.o_m0_rvalid), 32'd0);
    check("rd0_hold",    bus.o_m0_rdata, 32'hDEADBEEF);
    check("rd0_owner0",  32'(bus.o_owner), 32'd0);

    // m1 read returns to m1 only
    @(negedge i_clk);
    bus.i_m1_req = 1'b1; bus.i_m1_addr = 32'h20; bus.i_m1_funct3 = 3'b001;
    bus.i_lsu_ld_data = 32'h12345678;
    #1;
    check("rd1_gnt1", 32'(bus.o_m1_gnt), 32'd1);
    check("rd1_addr", bus.o_lsu_addr, 32'h20);
    check("rd1_f3",   32'(bus.o_lsu_funct3), 32'd1);
    @(negedge i_clk);
    idle_inputs();
    #1;
    check("rd1_rv1",  32'(bus.o_m1_rvalid), 32'd1);
    check("rd1_data", bus.o_m1_rdata, 32'h12345678);
    check("rd1_rv0",  32'(bus.o_m0_rvalid), 32'd0);
    check("rd1_rd0",  bus.o_m0_rdata, 32'hDEADBEEF);

    // 3: continuous contention from a fresh reset
    @(negedge i_clk);
    i_reset = 1'b0;
    #2 i_reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk);
      bus.i_m0_req = 1'b1; bus.i_m0_addr = 32'h100;
      bus.i_m1_req = 1'b1; bus.i_m1_addr = 32'h200;
      #1;
`ifdef LSU_ARB_FIXED_PRIO_EN
      check($sformatf("rr_gnt0_%0d", i), 32'(bus.o_m0_gnt), 32'd1);
      check($sformatf("rr_gnt1_%0d", i), 32'(bus.o_m1_gnt), 32'd0);
`else
      check($sformatf("rr_gnt0_%0d", i), 32'(bus.o_m0_gnt), (i < 8 || i >= 16) ? 32'd1 : 32'd0);
      check($sformatf("rr_gnt1_%0d", i), 32'(bus.o_m1_gnt), (i >= 8 && i < 16) ? 32'd1 : 32'd0);
      check($sformatf("rr_addr_%0d", i), bus.o_lsu_addr, (i >= 8 && i < 16) ? 32'h200 : 32'h100);
`endif
    end

    // 4: m1 takes ownership alone, then holds it with lock past the cap
    @(negedge i_clk);
    bus.i_m0_req = 1'b0;
    #1;
    check("own1_gnt1", 32'(bus.o_m1_gnt), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      bus.i_m0_req = 1'b1; bus.i_m0_lock = 1'b1; bus.i_m1_lock = 1'b1;
      #1;
      check($sformatf("lock_gnt1_%0d", i), 32'(bus.o_m1_gnt), 32'd1);
      check($sformatf("lock_gnt0_%0d", i), 32'(bus.o_m0_gnt), 32'd0);
    end
    @(negedge i_clk);
    bus.i_m0_lock = 1'b0; bus.i_m1_lock = 1'b0;
    #1;
    check("unlock_gnt0", 32'(bus.o_m0_gnt), 32'd1);
    check("unlock_gnt1", 32'(bus.o_m1_gnt), 32'd0);
    check("unlock_own",  32'(bus.o_owner), 32'd2);

    // 5: m1 store, no load return
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    bus.i_m1_req = 1'b1; bus.i_m1_wren = 1'b1; bus.i_m1_addr = 32'h1000_0000;
    bus.i_m1_wdata = 32'h55; bus.i_m1_funct3 = 3'b010;
    #1;
    check("st_gnt1",  32'(bus.o_m1_gnt), 32'd1);
    check("st_wren",  32'(bus.o_lsu_wren), 32'd1);
    check("st_data",  bus.o_lsu_st_data, 32'h55);
    check("st_addr",  bus.o_lsu_addr, 32'h1000_0000);
    check("st_f3",    32'(bus.o_lsu_funct3), 32'd2);
    @(negedge i_clk);
    idle_inputs();
    #1;
    check("st_rv0",    32'(bus.o_m0_rvalid), 32'd0);
    check("st_rv1",    32'(bus.o_m1_rvalid), 32'd0);
    check("st_wren0",  32'(bus.o_lsu_wren), 32'd0);
    check("st_data0",  bus.o_lsu_st_data, 32'd0);
    check("st_owner",  32'(bus.o_owner), 32'd2);

    // 6: reset lands inside a granted read cycle
    @(negedge i_clk);
    bus.i_m0_req = 1'b1; bus.i_m0_addr = 32'h40; bus.i_lsu_ld_data = 32'hCAFEF00D;
    #1;
    check("rr_rst_gnt0", 32'(bus.o_m0_gnt), 32'd1);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    idle_inputs();
    #1;
    check("rr_rst_rv0",  32'(bus.o_m0_rvalid), 32'd0);
    check("rr_rst_rd0",  bus.o_m0_rdata, 32'd0);
    check("rr_rst_rd1",  bus.o_m1_rdata, 32'd0);
    i_reset = 1'b1;
    next_cycle();
    check_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
